// File: rtl/rr_unit_arbiter_if.sv
// Requester, shared-unit and response signals of rr_unit_arbiter.
// master = arbiter side, slave = fabric/unit side.
interface rr_unit_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic              unit_start;
    logic [W-1:0]      unit_i;
    logic [W-1:0]      unit_o;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_data;
    logic              busy;

    modport master (
        input  req, req_data, unit_o, rsp_ready,
        output gnt, unit_start, unit_i, rsp_valid, rsp_id, rsp_data, busy
    );

    modport slave (
        output req, req_data, unit_o, rsp_ready,
        input  gnt, unit_start, unit_i, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/rr_unit_arbiter.sv
// Round-robin sharing of one LAT-cycle unit among NREQ requesters; response LAT edges after grant.
// A stalled response (rsp_ready low) holds the arbiter in RESP and blocks further grants.
module rr_unit_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int LAT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    rr_unit_arbiter_if.master bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_RESP
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDW-1:0]  r_ptr;
    logic [7:0]      r_cnt;
    logic [NREQ-1:0] r_gnt;
    logic            r_unit_start;
    logic [W-1:0]    r_unit_i;
    logic            r_rsp_valid;
    logic [IDW-1:0]  r_rsp_id;
    logic [W-1:0]    r_rsp_data;

    logic            w_found;
    logic [IDW-1:0]  w_winner;
    logic [NREQ-1:0] w_gnt_oh;
    int              w_idx;

    // First pending requester at or after the rotation pointer, wrapping at NREQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NREQ;
            if (!w_found && bus.req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = IDW'(w_idx);
            end
        end
    end

    assign w_gnt_oh = NREQ'(1) << w_winner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found)       w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == 8'd0) w_state_nxt = S_RESP;
            S_RESP:  if (bus.rsp_ready) w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr        <= '0;
            r_cnt        <= '0;
            r_gnt        <= '0;
            r_unit_start <= 1'b0;
            r_unit_i     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_data   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt        <= w_gnt_oh;
                        r_unit_start <= 1'b1;
                        r_unit_i     <= bus.req_data[int'(w_winner)*W +: W];
                        r_rsp_id     <= w_winner;
                        r_cnt        <= 8'(LAT - 1);
                    end
                end
                S_RUN: begin
                    r_gnt        <= '0;
                    r_unit_start <= 1'b0;
                    if (r_cnt == 8'd0) begin
                        r_rsp_data  <= bus.unit_o;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        // Wrap explicitly: NREQ need not be a power of two.
                        if (r_rsp_id == IDW'(NREQ - 1)) begin
                            r_ptr <= '0;
                        end else begin
                            r_ptr <= r_rsp_id + IDW'(1);
                        end
                    end
                end
                default: begin
                    r_gnt        <= '0;
                    r_unit_start <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.unit_start = r_unit_start;
    assign bus.unit_i     = r_unit_i;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_rr_unit_arbiter.sv
// Directed bench for rr_unit_arbiter (NREQ=4, W=4, LAT=2) with a bit-reversing unit model.
module tb_rr_unit_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [3:0] unit_q;

    rr_unit_arbiter_if #(.NREQ(4), .W(4)) bus ();

    rr_unit_arbiter #(.NREQ(4), .W(4), .LAT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unit model: bit reverse, result valid by the second edge after issue.
    initial unit_q = 4'h0;
    always @(posedge clk) unit_q <= {bus.unit_i[0], bus.unit_i[1], bus.unit_i[2], bus.unit_i[3]};
    assign bus.unit_o = unit_q;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] data;
        int          id;
        logic [3:0]  rsp;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int oh2id(input logic [3:0] oh);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (oh[i]) r = i;
        return r;
    endfunction

    // One full operation starting from IDLE; request is dropped after its grant.
    task automatic txn(input logic [3:0] rq, input logic [15:0] rd, input int exp_id,
                       input logic [3:0] exp_rsp);
        logic [15:0] dv;
        logic [3:0]  op;
        dv = rd;
        op = dv[exp_id*4 +: 4];
        bus.req       = rq;
        bus.req_data  = rd;
        bus.rsp_ready = 1'b0;
        tick();
        chk("grant_onehot", 32'(bus.gnt), 32'(4'b0001 << exp_id));
        chk("unit_start", 32'(bus.unit_start), 32'd1);
        chk("unit_i", 32'(bus.unit_i), 32'(op));
        chk("busy_run", 32'(bus.busy), 32'd1);
        bus.req = 4'b0000;
        tick();
        chk("gnt_pulse_end", 32'(bus.gnt), 32'd0);
        chk("start_pulse_end", 32'(bus.unit_start), 32'd0);
        chk("rsp_valid_early", 32'(bus.rsp_valid), 32'd0);
        chk("unit_i_held", 32'(bus.unit_i), 32'(op));
        tick();
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rsp_id", 32'(bus.rsp_id), 32'(exp_id));
        chk("rsp_data", 32'(bus.rsp_data), 32'(exp_rsp));
        bus.rsp_ready = 1'b1;
        tick();
        chk("rsp_valid_clr", 32'(bus.rsp_valid), 32'd0);
        chk("busy_idle", 32'(bus.busy), 32'd0);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
        chk({tag, "_unit_start"}, 32'(bus.unit_start), 32'd0);
        chk({tag, "_unit_i"}, 32'(bus.unit_i), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'd0);
        chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g_ids[$];
        int g_cyc[$];
        int n_gnt1;
        int n_gnt;

        checks = 0;
        errors = 0;
        // Pointer carries across rows: 0 ->3 ->0 ->1 ->2 ->1 ->2 ->0.
        vecs[0] = '{req: 4'b0100, data: 16'h0300, id: 2, rsp: 4'hC};
        vecs[1] = '{req: 4'b1001, data: 16'hA006, id: 3, rsp: 4'h5};
        vecs[2] = '{req: 4'b1001, data: 16'hA006, id: 0, rsp: 4'h6};
        vecs[3] = '{req: 4'b0011, data: 16'h00E1, id: 1, rsp: 4'h7};
        vecs[4] = '{req: 4'b0001, data: 16'h0008, id: 0, rsp: 4'h1};
        vecs[5] = '{req: 4'b1111, data: 16'h4321, id: 1, rsp: 4'h4};
        vecs[6] = '{req: 4'b1010, data: 16'hF0A0, id: 3, rsp: 4'hF};

        rst           = 1'b0;
        bus.req       = 4'b0000;
        bus.req_data  = 16'h0000;
        bus.rsp_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk_all_zero("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("idle_no_req_gnt", 32'(bus.gnt), 32'd0);
        chk("idle_no_req_busy", 32'(bus.busy), 32'd0);

        for (int v = 0; v < 7; v++) begin
            txn(vecs[v].req, vecs[v].data, vecs[v].id, vecs[v].rsp);
        end

        // Continuous requests, rsp_ready tied high: pointer is 0 here.
        bus.req       = 4'b1111;
        bus.req_data  = 16'h9C63;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 40 && g_ids.size() < 5; c++) begin
            tick();
            if (bus.gnt != 4'b0000) begin
                chk("rr_onehot", 32'($countones(bus.gnt)), 32'd1);
                g_ids.push_back(oh2id(bus.gnt));
                g_cyc.push_back(c);
            end
        end
        bus.req = 4'b0000;
        chk("rr_grant_count", 32'(g_ids.size()), 32'd5);
        for (int i = 0; i < g_ids.size(); i++) begin
            chk("rr_order", 32'(g_ids[i]), 32'(i % 4));
            if (i > 0) chk("rr_gap", 32'(g_cyc[i] - g_cyc[i-1]), 32'd4);
        end
        for (int c = 0; c < 10; c++) begin
            if (!bus.busy) break;
            tick();
        end
        chk("rr_drain_idle", 32'(bus.busy), 32'd0);
        bus.rsp_ready = 1'b0;

        // Backpressure with another request waiting; pointer is 1.
        bus.req      = 4'b1100;
        bus.req_data = 16'h3500;
        tick();
        chk("bp_grant", 32'(bus.gnt), 32'b0100);
        tick();
        tick();
        chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_hold_id", 32'(bus.rsp_id), 32'd2);
            chk("bp_hold_data", 32'(bus.rsp_data), 32'hA);
            chk("bp_no_gnt", 32'(bus.gnt), 32'd0);
            chk("bp_no_start", 32'(bus.unit_start), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
        chk("bp_release_no_gnt", 32'(bus.gnt), 32'd0);
        bus.rsp_ready = 1'b0;
        tick();
        chk("bp_next_grant", 32'(bus.gnt), 32'b1000);
        chk("bp_next_unit_i", 32'(bus.unit_i), 32'h3);
        bus.req = 4'b0000;
        tick();
        tick();
        chk("bp_next_rsp", 32'(bus.rsp_data), 32'hC);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // Reset mid-RUN with the pointer moved to 3 first.
        txn(4'b0100, 16'h0700, 2, 4'hE);
        bus.req      = 4'b1000;
        bus.req_data = 16'h1000;
        tick();
        chk("rst_pre_grant", 32'(bus.gnt), 32'b1000);
        tick();
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid_run");
        bus.req      = 4'b1010;
        bus.req_data = 16'h00B0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        rst = 1'b0;
        tick();
        chk("rst_first_grant", 32'(bus.gnt), 32'b0010);
        chk("rst_first_id", 32'(bus.rsp_id), 32'd1);
        bus.req = 4'b0000;
        tick();
        tick();
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'hD);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // Withdrawal: req[1] raised during RUN, dropped before the IDLE edge.
        n_gnt1       = 0;
        n_gnt        = 0;
        bus.req      = 4'b0001;
        bus.req_data = 16'h0004;
        tick();
        chk("wd_grant0", 32'(bus.gnt), 32'b0001);
        bus.req = 4'b0010;
        tick();
        if (bus.gnt[1]) n_gnt1++;
        tick();
        chk("wd_rsp_data", 32'(bus.rsp_data), 32'h2);
        bus.rsp_ready = 1'b1;
        tick();
        if (bus.gnt[1]) n_gnt1++;
        bus.req       = 4'b0000;
        bus.rsp_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.gnt[1]) n_gnt1++;
            if (bus.gnt != 4'b0000) n_gnt++;
        end
        chk("wd_never_gnt1", 32'(n_gnt1), 32'd0);
        chk("wd_no_gnt", 32'(n_gnt), 32'd0);
        chk("wd_idle", 32'(bus.busy), 32'd0);
        txn(4'b1000, 16'h5000, 3, 4'hA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
